// File: rtl/gf26_pkg.sv
// gf26_pkg -- shared types and constants for the GF(2^6) arithmetic blocks.
//   gf_elem_t   : one field element (6 bits)
//   GF_M        : field degree
//   GF_POLY     : primitive polynomial x^6 + x + 1
//   arb_state_t : states of the shared-multiplier arbiter
package gf26_pkg;

    localparam int         GF_M    = 6;
    localparam logic [6:0] GF_POLY = 7'h43;

    typedef logic [GF_M-1:0] gf_elem_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/gf26_mul_arbiter_if.sv
// gf26_mul_arbiter_if -- bundles the requester side and the multiplier side
// of the shared GF(2^6) multiplier arbiter.
//   slave  : arbiter view (takes req/operands and mul_done/mul_z,
//            drives gnt/done/result/busy and the multiplier start/operands)
//   master : view of the clients plus the multiplier instance
// Requester i uses op_a/op_b bits [6i+5:6i].
interface gf26_mul_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import gf26_pkg::*;

    logic [NUM_REQ-1:0]      req;
    logic [GF_M*NUM_REQ-1:0] op_a;
    logic [GF_M*NUM_REQ-1:0] op_b;
    logic [NUM_REQ-1:0]      gnt;
    logic [NUM_REQ-1:0]      done;
    gf_elem_t                result;
    logic                    busy;
    logic                    mul_start;
    gf_elem_t                mul_a;
    gf_elem_t                mul_b;
    logic                    mul_done;
    gf_elem_t                mul_z;

    modport slave (
        input  req, op_a, op_b, mul_done, mul_z,
        output gnt, done, result, busy, mul_start, mul_a, mul_b
    );

    modport master (
        output req, op_a, op_b, mul_done, mul_z,
        input  gnt, done, result, busy, mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/gf26_mul_arbiter_rr_arbiter.sv
// rr_arbiter -- combinational round-robin pick.
//   i_req : request vector
//   i_ptr : index with highest priority this round
//   o_gnt : one-hot winner (all zero when no request)
//   o_idx : index of the winner
//   o_any : at least one request present
// Search order is ptr, ptr+1, ... wrapping modulo N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_c;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_c   = 0;
        for (int k = 0; k < N; k++) begin
            w_c = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_c]) begin
                o_any      = 1'b1;
                o_gnt[w_c] = 1'b1;
                o_idx      = IW'(w_c);
            end
        end
    end

endmodule

// File: rtl/gf26_mul_arbiter.sv
// gf26_mul_arbiter -- shares one multi-cycle GF(2^6) multiplier between
// NUM_REQ requesters with round-robin arbitration.
//   clk, resetN : clock, synchronous active-low reset
//   bus (slave) : req/op_a/op_b in, gnt/done/result/busy out,
//                 mul_start/mul_a/mul_b out, mul_done/mul_z in
//   err         : sticky watchdog flag (only with GF26_ARB_TIMEOUT_EN)
// Optional macro GF26_ARB_TIMEOUT_EN: WAIT gives up after TIMEOUT cycles,
// answers the owner with result 0 and sets err.
module gf26_mul_arbiter
    import gf26_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                resetN,
    gf26_mul_arbiter_if.slave   bus
`ifdef GF26_ARB_TIMEOUT_EN
    ,
    output logic                err
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("gf26_mul_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    arb_state_t         r_state,  w_state_nx;
    logic [NUM_REQ-1:0] r_gnt,    w_gnt_nx;
    logic [NUM_REQ-1:0] r_done,   w_done_nx;
    gf_elem_t           r_result, w_result_nx;
    gf_elem_t           r_mul_a,  w_mul_a_nx;
    gf_elem_t           r_mul_b,  w_mul_b_nx;
    logic [IW-1:0]      r_ptr,    w_ptr_nx;
    logic [IW-1:0]      r_gidx,   w_gidx_nx;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [IW-1:0]      w_arb_idx;
    logic               w_arb_any;

`ifdef GF26_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_wcnt, w_wcnt_nx;
    logic          r_err,  w_err_nx;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_gnt_nx    = r_gnt;
        w_done_nx   = '0;          // done is a single-cycle pulse
        w_result_nx = r_result;
        w_mul_a_nx  = r_mul_a;
        w_mul_b_nx  = r_mul_b;
        w_ptr_nx    = r_ptr;
        w_gidx_nx   = r_gidx;
`ifdef GF26_ARB_TIMEOUT_EN
        w_wcnt_nx   = r_wcnt;
        w_err_nx    = r_err;
`endif
        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    // Operands are captured here; the requester may change them afterwards.
                    w_gnt_nx   = w_arb_gnt;
                    w_gidx_nx  = w_arb_idx;
                    w_mul_a_nx = bus.op_a[int'(w_arb_idx)*GF_M +: GF_M];
                    w_mul_b_nx = bus.op_b[int'(w_arb_idx)*GF_M +: GF_M];
                    w_state_nx = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nx = WAIT;
`ifdef GF26_ARB_TIMEOUT_EN
                w_wcnt_nx  = '0;
`endif
            end
            WAIT: begin
                if (bus.mul_done) begin
                    w_result_nx = bus.mul_z;
                    w_done_nx   = r_gnt;
                    w_state_nx  = RESP;
                end
`ifdef GF26_ARB_TIMEOUT_EN
                else if (r_wcnt == TW'(TIMEOUT - 1)) begin
                    w_result_nx = '0;
                    w_done_nx   = r_gnt;
                    w_err_nx    = 1'b1;
                    w_state_nx  = RESP;
                end else begin
                    w_wcnt_nx = r_wcnt + 1'b1;
                end
`endif
            end
            RESP: begin
                // req is deliberately not sampled here so a requester that
                // drops req on its done pulse cannot be granted twice.
                w_ptr_nx   = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
                w_gnt_nx   = '0;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_ptr    <= '0;
            r_gidx   <= '0;
`ifdef GF26_ARB_TIMEOUT_EN
            r_wcnt   <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_gnt    <= w_gnt_nx;
            r_done   <= w_done_nx;
            r_result <= w_result_nx;
            r_mul_a  <= w_mul_a_nx;
            r_mul_b  <= w_mul_b_nx;
            r_ptr    <= w_ptr_nx;
            r_gidx   <= w_gidx_nx;
`ifdef GF26_ARB_TIMEOUT_EN
            r_wcnt   <= w_wcnt_nx;
            r_err    <= w_err_nx;
`endif
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.mul_start = (r_state == ISSUE);
    assign bus.busy      = (r_state != IDLE);
`ifdef GF26_ARB_TIMEOUT_EN
    assign err           = r_err;
`endif

endmodule

// File: tb/tb_gf26_mul_arbiter.sv
// tb_gf26_mul_arbiter -- directed bench for gf26_mul_arbiter with a
// transaction-level reference model and a behavioural multiplier.
// Honours GF26_ARB_TIMEOUT_EN when defined (watchdog scenario, err port).
module tb_gf26_mul_arbiter;
    import gf26_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    gf26_mul_arbiter_if #(.NUM_REQ(N)) bus ();
`ifdef GF26_ARB_TIMEOUT_EN
    logic err;
`endif

    gf26_mul_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
`ifdef GF26_ARB_TIMEOUT_EN
        ,
        .err    (err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Plain shift-and-add GF(2^6) product reduced by x^6+x+1.
    function automatic gf_elem_t gf_mul(input gf_elem_t a, input gf_elem_t b);
        logic [6:0] aa;
        gf_elem_t   p;
        aa = {1'b0, a};
        p  = '0;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ aa[5:0];
            aa = aa << 1;
            if (aa[6]) aa = aa ^ 7'h43;
        end
        return p;
    endfunction

    function automatic int idx_of(input logic [N-1:0] g);
        for (int k = 0; k < N; k++) if (g[k]) return k;
        return -1;
    endfunction

    // Behavioural multiplier controls
    int       lat        = 1;
    bit       mul_en     = 1'b1;
    bit       force_done = 1'b0;
    gf_elem_t force_z    = '0;
    int       mcnt       = 0;
    gf_elem_t la, lb;

    // Reference model: who owns the multiplier, at which step, what it returns
    int       m_owner = -1;
    int       m_age   = 0;
    int       m_ptr   = 0;
    bit       m_resp  = 1'b0;
    bit       m_valid = 1'b0;
    bit       m_err   = 1'b0;
    gf_elem_t m_a = '0, m_b = '0, m_res = '0;

    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (m_valid) begin
            eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            chk("gnt",        32'(bus.gnt),       32'(eg));
            chk("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
            chk("done",       32'(bus.done),      32'(m_resp ? eg : '0));
            chk("result",     32'(bus.result),    32'(m_res));
            chk("busy",       32'(bus.busy),      32'(m_owner >= 0));
            chk("mul_start",  32'(bus.mul_start), 32'(m_owner >= 0 && m_age == 1));
            chk("mul_a",      32'(bus.mul_a),     32'(m_a));
            chk("mul_b",      32'(bus.mul_b),     32'(m_b));
`ifdef GF26_ARB_TIMEOUT_EN
            chk("err",        32'(err),           32'(m_err));
`endif
        end
        // multiplier: answers lat cycles after the start it saw
        if (force_done) begin
            bus.mul_done = 1'b1;
            bus.mul_z    = force_z;
        end else begin
            bus.mul_done = 1'b0;
            if (bus.mul_start && mul_en) begin
                mcnt = lat;
                la   = bus.mul_a;
                lb   = bus.mul_b;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    bus.mul_done = 1'b1;
                    bus.mul_z    = gf_mul(la, lb);
                end
            end
        end
        // model advances using what the DUT will sample at the next edge
        if (!resetN) begin
            m_owner = -1; m_ptr = 0; m_resp = 1'b0; m_err = 1'b0;
            m_a = '0; m_b = '0; m_res = '0; m_valid = 1'b1;
        end else if (!m_valid) begin
            m_owner = -1;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (m_owner < 0 && bus.req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            if (m_owner >= 0) begin
                m_age = 1;
                m_a   = bus.op_a[6*m_owner +: 6];
                m_b   = bus.op_b[6*m_owner +: 6];
            end
        end else if (m_resp) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_resp  = 1'b0;
        end else begin
            if (m_age >= 2 && bus.mul_done) begin
                m_resp = 1'b1;
                m_res  = bus.mul_z;
            end
`ifdef GF26_ARB_TIMEOUT_EN
            else if (m_age >= 2 && m_age - 1 == TO) begin
                m_resp = 1'b1;
                m_res  = '0;
                m_err  = 1'b1;
            end
`endif
            m_age++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic set_op(input int i, input gf_elem_t a, input gf_elem_t b);
        bus.op_a[6*i +: 6] = a;
        bus.op_b[6*i +: 6] = b;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = -1;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (bus.done != '0) begin
                cyc = i + 1;
                break;
            end
        end
        if (cyc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: no done pulse within %0d cycles", maxc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int       cyc;
        int       order[$];
        int       exp_order[5];
        gf_elem_t g;

        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;

        // model pins: hand-computed field products
        g = gf_mul(6'h05, 6'h03); chk("pin_5x3",   32'(g), 32'h0F);
        g = gf_mul(6'h3F, 6'h01); chk("pin_3Fx1",  32'(g), 32'h3F);
        g = gf_mul(6'h20, 6'h02); chk("pin_x6",    32'(g), 32'h03);
        g = gf_mul(6'h00, 6'h2A); chk("pin_zero",  32'(g), 32'h00);

        // reset state
        do_reset();
        tick();
        chk("rst_gnt",   32'(bus.gnt),       32'h0);
        chk("rst_done",  32'(bus.done),      32'h0);
        chk("rst_busy",  32'(bus.busy),      32'h0);
        chk("rst_start", 32'(bus.mul_start), 32'h0);
        chk("rst_res",   32'(bus.result),    32'h0);

        // single request, 1-cycle multiplier
        lat = 1;
        set_op(1, 6'h05, 6'h03);
        bus.req = 4'b0010;
        tick();
        chk("t1_start", 32'(bus.mul_start), 32'h1);
        chk("t1_gnt",   32'(bus.gnt),       32'b0010);
        tick();
        chk("t1_nodone_yet", 32'(bus.done), 32'h0);
        tick();
        chk("t1_done",   32'(bus.done),   32'b0010);
        chk("t1_result", 32'(bus.result), 32'h0F);
        bus.req = '0;
        tick();
        chk("t1_idle", 32'(bus.busy), 32'h0);
        tick();

        // all four requesting, latency 5: order 0,1,2,3,0
        do_reset();
        lat = 5;
        for (int i = 0; i < N; i++) set_op(i, gf_elem_t'(i + 1), gf_elem_t'(i + 9));
        bus.req = 4'b1111;
        for (int c = 0; c < 100 && order.size() < 5; c++) begin
            tick();
            if (bus.mul_start) order.push_back(idx_of(bus.gnt));
        end
        bus.req = '0;
        wait_done(20, cyc);
        tick();
        tick();
        exp_order = '{0, 1, 2, 3, 0};
        chk("t2_grants", 32'(order.size()), 32'd5);
        for (int k = 0; k < 5 && k < order.size(); k++)
            chk($sformatf("t2_order%0d", k), 32'(order[k]), 32'(exp_order[k]));

        // requester 2 drops after its done; requester 3 next
        do_reset();
        lat = 2;
        set_op(2, 6'h11, 6'h22);
        set_op(3, 6'h07, 6'h05);
        bus.req = 4'b1100;
        wait_done(20, cyc);
        chk("t3_first_done", 32'(bus.done), 32'b0100);
        tick();
        bus.req = 4'b1000;
        cyc = -1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.mul_start) begin
                cyc = c;
                break;
            end
        end
        chk("t3_next_gnt", 32'(bus.gnt), 32'b1000);
        wait_done(20, cyc);
        chk("t3_second_done", 32'(bus.done), 32'b1000);
        bus.req = '0;
        tick();
        tick();

        // reset during WAIT, then a stale mul_done
        mul_en = 1'b0;
        set_op(0, 6'h07, 6'h09);
        bus.req = 4'b0001;
        tick();
        tick();
        tick();
        chk("t4_busy_before", 32'(bus.busy), 32'h1);
        resetN  = 1'b0;
        bus.req = '0;
        tick();
        resetN = 1'b1;
        tick();
        force_z    = 6'h2A;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        chk("t4_busy",   32'(bus.busy),   32'h0);
        chk("t4_gnt",    32'(bus.gnt),    32'h0);
        chk("t4_done",   32'(bus.done),   32'h0);
        chk("t4_result", 32'(bus.result), 32'h0);
        chk("t4_mul_a",  32'(bus.mul_a),  32'h0);
        chk("t4_mul_b",  32'(bus.mul_b),  32'h0);
        mul_en = 1'b1;

        // operand changes after latch do not matter
        lat = 3;
        set_op(0, 6'h3F, 6'h01);
        bus.req = 4'b0001;
        tick();
        tick();
        set_op(0, 6'h00, 6'h01);
        wait_done(20, cyc);
        chk("t5_result", 32'(bus.result), 32'h3F);
        chk("t5_mul_a",  32'(bus.mul_a),  32'h3F);
        bus.req = '0;
        tick();

        // zero operand and polynomial reduction
        set_op(3, 6'h00, 6'h2A);
        bus.req = 4'b1000;
        wait_done(20, cyc);
        chk("t6_zero", 32'(bus.result), 32'h00);
        bus.req = '0;
        tick();
        set_op(3, 6'h20, 6'h02);
        bus.req = 4'b1000;
        wait_done(20, cyc);
        chk("t6_reduce", 32'(bus.result), 32'h03);
        bus.req = '0;
        tick();
        tick();

`ifdef GF26_ARB_TIMEOUT_EN
        // multiplier never answers: watchdog fires after TO WAIT cycles
        do_reset();
        mul_en = 1'b0;
        set_op(1, 6'h05, 6'h05);
        bus.req = 4'b0010;
        wait_done(40, cyc);
        chk("t7_latency", 32'(cyc), 32'(TO + 2));
        chk("t7_done",    32'(bus.done),   32'b0010);
        chk("t7_result",  32'(bus.result), 32'h0);
        chk("t7_err",     32'(err),        32'h1);
        bus.req = '0;
        tick();
        tick();
        chk("t7_err_sticky", 32'(err), 32'h1);
        do_reset();
        tick();
        chk("t7_err_clear", 32'(err), 32'h0);
        mul_en = 1'b1;
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gf26_mul_arbiter.md
Name: gf26_mul_arbiter

Overview:
- Shares one multi-cycle GF(2^6) multiplier (start/done handshake, result valid with done) between NUM_REQ requesters, e.g. the exponentiation units and syndrome/Chien engines of the RS codec.
- Round-robin arbitration. Latches the winner's operands, sequences one multiplication at a time and returns the product to that requester only.
- Sits between the GF(2^6) arithmetic clients and the single shared multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- resetN  in  1  reset; one clock, reset synchronous active-low.
- req  in  NUM_REQ  per-requester multiply request, level.
- op_a  in  6*NUM_REQ  operand A; requester i in bits [6i+5:6i].
- op_b  in  6*NUM_REQ  operand B, same packing.
- gnt  out  NUM_REQ  one-hot owner of the multiplier.
- done  out  NUM_REQ  one-cycle pulse to the owner: result valid.
- result  out  6  product, valid while done is high; holds otherwise.
- busy  out  1  high in any state other than IDLE.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  6  registered operand A to the multiplier.
- mul_b  out  6  registered operand B to the multiplier.
- mul_done  in  1  multiplier completion pulse.
- mul_z  in  6  multiplier product, valid with mul_done.

Behaviour:
- Reset (resetN low at posedge): gnt, done, result, mul_a, mul_b = 0; mul_start, busy = 0; state = IDLE; rr pointer = 0.
  - An operation in flight is abandoned.
  - A late mul_done is ignored because the state is IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, pick the first set bit searching from ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - Register gnt, mul_a and mul_b from that requester's slice; go to ISSUE.
  - With no request, stay in IDLE; all outputs hold.
- ISSUE: mul_start = 1 for exactly this cycle; go to WAIT.
- WAIT:
  - On mul_done: result <= mul_z, done[g] <= 1, go to RESP.
  - Otherwise stay in WAIT. mul_done seen in any other state is ignored.
- RESP:
  - done high for this one cycle.
  - ptr <= (g+1) mod NUM_REQ; gnt <= 0; go to IDLE.
  - req is not sampled in RESP, so a requester dropping req on done cannot be double-granted.
- Handshake rules:
  - A requester holds req and its operands stable until its done pulse.
  - Operands are latched in IDLE, so later changes do not affect the current operation.
  - A req held high after done is treated as a new request.
  - Dropping req after grant does not cancel the operation; done still pulses.
- Latency:
  - Request seen at cycle 0 → mul_start at cycle 1.
  - mul_done at cycle k → done/result at cycle k+1 → IDLE at cycle k+2.
  - Minimum request-to-done is 3 cycles, for a 1-cycle multiplier.
- Fairness: with all requesters continuously active, grant order is 0,1,...,NUM_REQ-1,0,... Any active requester waits at most NUM_REQ-1 operations.
- Simultaneous events:
  - Multiple req bits in IDLE: round-robin decides.
  - mul_done in the same cycle the FSM enters WAIT is accepted.
- Boundary: zero operands pass through unmodified; the multiplier defines 0·x = 0.

Optional Feature:
- Macro GF26_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT and counts WAIT cycles.
  - At TIMEOUT cycles without mul_done, the FSM goes to RESP with result = 0 and done[g] pulsed.
  - A sticky output port err (1 bit) is set; it is cleared only by reset.
- Without the macro: no counter, no err port, and WAIT waits indefinitely.

Decomposition:
- Package gf26_pkg:
  - typedef gf_elem_t (logic [5:0]).
  - GF_M = 6.
  - primitive polynomial constant GF_POLY = 7'h43 (x^6+x+1).
  - FSM state enum arb_state_t.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req and ptr.
  - Outputs: one-hot grant and its index.
  - Reusable by later shared adders/inverters.

Test Plan:
- Single request: req=4'b0010, op_a=6'h05, op_b=6'h03, 1-cycle multiplier model → mul_start at cycle 1, done[1] at cycle 3, result=6'h0F, gnt=4'b0010 during the operation.
- All four req high continuously, multiplier latency 5 → grants 0,1,2,3,0; each done pulse exactly one cycle; no two gnt bits ever high together.
- req[2] dropped the cycle after done[2] while req[3] is high → next gnt=4'b1000; requester 2 is not re-granted.
- resetN low during WAIT, then a stale mul_done two cycles after release → all outputs 0, FSM in IDLE, no done pulse.
- op_a changed while busy: a=6'h3F, b=6'h01 latched, op_a switched to 0 mid-WAIT → result=6'h3F.
- With GF26_ARB_TIMEOUT_EN, TIMEOUT=8, multiplier never answers → done pulse at WAIT cycle 8, result=0, err=1 and sticky until reset.
